// File: rtl/bsg_mc_pkg.sv
// Shared types and register-map constants for the multi-channel bit stream generator.
package bsg_mc_pkg;

  typedef enum logic {
    MODE_NRZ   = 1'b0,
    MODE_MANCH = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

  localparam logic [5:0] ADDR_CTRL   = 6'h20;
  localparam logic [5:0] ADDR_STATUS = 6'h21;
  localparam logic [7:0] CTRL_RST    = 8'h01;

endpackage

// File: rtl/bsg_ch_serializer.sv
// One transmit channel: hold register, framing state machine, bit timer and NRZ/Manchester encoder.
module bsg_ch_serializer
  import bsg_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  enable,
  input  logic                  mode,
  output logic                  hold_full,
  output logic                  tx_out,
  output logic                  tx_busy
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  ser_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] hold, shreg;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  mode_t                 frame_mode;
  logic                  bit_end, load, bit_val, line_d, busy_d;

  assign bit_end = (cnt == CNT_W'(BIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      idx        <= '0;
      frame_mode <= MODE_NRZ;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_out  <= line_d;
      tx_busy <= busy_d;
      // push only happens while the hold is empty, load only while it is full
      if (push) begin
        hold      <= push_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        shreg      <= hold;
        frame_mode <= mode_t'(mode);
        cnt        <= '0;
        idx        <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
        if (state == DATA && bit_end) begin
          shreg <= shreg >> 1;
          idx   <= idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full && enable) begin
          state_nxt = START;
          load      = 1'b1;
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && idx == IDX_W'(DATA_WIDTH - 1)) state_nxt = STOP;
      STOP: begin
        if (bit_end) begin
          if (hold_full && enable) begin
            state_nxt = START;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // line and busy are registered, so they trail the state by one cycle
  always_comb begin
    bit_val = 1'b1;
    busy_d  = 1'b1;
    case (state)
      IDLE:    busy_d  = 1'b0;
      START:   bit_val = 1'b0;
      DATA:    bit_val = shreg[0];
      STOP:    bit_val = 1'b1;
      default: busy_d  = 1'b0;
    endcase
    line_d = bit_val;
    if (state != IDLE && frame_mode == MODE_MANCH && cnt < CNT_W'(BIT_CYCLES / 2))
      line_d = ~bit_val;
  end

endmodule

// File: rtl/bsg_mc_core.sv
// Multi-channel bit stream generator: register decode, access handshake, read mux and channel array.
module bsg_mc_core
  import bsg_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] amba_data_out,
  output logic [NUM_CH-1:0]     tx_out,
  output logic [NUM_CH-1:0]     tx_busy
);

  logic                  is_rd, wr_acc, rd_acc;
  logic [5:0]            reg_addr;
  logic                  ctrl_en;
  mode_t                 ctrl_mode;
  logic [NUM_CH-1:0]     hit, push, hold_full;
  logic [2*NUM_CH-1:0]   status_raw;
  logic [DATA_WIDTH-1:0] status, rd_data;
  logic                  unused_addr_bits;

  assign is_rd            = addr_in[DATA_WIDTH-1];
  assign reg_addr         = addr_in[5:0];
  assign unused_addr_bits = ^addr_in[DATA_WIDTH-2:6];

  // decided on the current hold_full, so a write stalls even on the cycle the hold drains
  assign ready  = !(valid && !is_rd && |(hit & hold_full));
  assign wr_acc = valid && ready && !is_rd;
  assign rd_acc = valid && ready && is_rd;

  assign status_raw = {tx_busy, hold_full};
  if (2 * NUM_CH >= DATA_WIDTH) begin : g_st_trunc
    assign status = status_raw[DATA_WIDTH-1:0];
  end else begin : g_st_ext
    assign status = {{(DATA_WIDTH - 2 * NUM_CH){1'b0}}, status_raw};
  end

  always_comb begin
    rd_data = '0;
    if (reg_addr == ADDR_CTRL) begin
      rd_data[0] = ctrl_en;
      rd_data[1] = ctrl_mode;
    end else if (reg_addr == ADDR_STATUS) begin
      rd_data = status;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      ctrl_en       <= CTRL_RST[0];
      ctrl_mode     <= mode_t'(CTRL_RST[1]);
      amba_data_out <= '0;
    end else begin
      if (wr_acc && reg_addr == ADDR_CTRL) begin
        ctrl_en   <= data_in[0];
        ctrl_mode <= mode_t'(data_in[1]);
      end
      if (rd_acc) amba_data_out <= rd_data;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit[g]  = (reg_addr == 6'(g));
    assign push[g] = wr_acc && hit[g];

    bsg_ch_serializer #(
      .DATA_WIDTH(DATA_WIDTH),
      .BIT_CYCLES(BIT_CYCLES)
    ) u_ser (
      .clk      (SYS_CLK),
      .rst      (rst),
      .push     (push[g]),
      .push_data(data_in),
      .enable   (ctrl_en),
      .mode     (ctrl_mode),
      .hold_full(hold_full[g]),
      .tx_out   (tx_out[g]),
      .tx_busy  (tx_busy[g])
    );
  end

endmodule

// File: doc/bsg_mc_core.md
Name: bsg_mc_core

Overview:
- Multi-channel, parametrised successor to the single-channel bit stream generator (BSG) datapath.
- Register-mapped write/read port loads per-channel transmit bytes, a control register and a status register.
- Each channel has a double-buffered framing serializer with selectable NRZ or Manchester line coding.
- Sits under the bsg top level, between the AMBA-side register interface and the transmit pins; all logic runs on SYS_CLK.

Parameters:
- DATA_WIDTH, 8, register/data width and payload bits per frame; must be at least 8.
- NUM_CH, 4, number of transmit channels; 1..DATA_WIDTH (status fits one word).
- BIT_CYCLES, 4, SYS_CLK cycles per line bit; even, at least 2.

Ports:
- SYS_CLK  in  1  system clock, single clock domain.
- rst  in  1  reset; synchronous, active-high.
- valid  in  1  access request.
- addr_in  in  DATA_WIDTH  address; MSB=1 read, MSB=0 write.
- data_in  in  DATA_WIDTH  write data.
- ready  out  1  access accepted when valid&&ready at rising edge.
- amba_data_out  out  DATA_WIDTH  read data, registered.
- tx_out  out  NUM_CH  serial line per channel; idle level 1.
- tx_busy  out  NUM_CH  channel is sending a frame.

Behaviour:
- Address map, low 6 bits (a):
  - a=0..NUM_CH-1: channel data (write pushes the channel hold register).
  - a=0x20: CTRL. bit0 = enable, bit1 = mode (0 NRZ, 1 Manchester). Read and write.
  - a=0x21: STATUS, read-only. bit i = hold_full[i], bit NUM_CH+i = tx_busy[i], when those bits fit in DATA_WIDTH.
- Other addresses: writes are accepted and ignored; reads return 0.
- Reset values: ready=1, amba_data_out=0, tx_out=all 1, tx_busy=0, hold_full=0, CTRL=0x01 (enabled, NRZ).
- Reset mid-frame: line returns to 1 at the next edge and all pending data is discarded.
- ready: drops to 0 only for a write to channel i while hold_full[i]=1. It is decided on the current hold_full, so a write is blocked even on the cycle the hold drains. Reads are always ready.
- Write accepted at edge E: hold[i] loaded and hold_full[i]=1 after E.
- Read accepted at edge E: amba_data_out is updated after E and held until the next accepted read.
- Serializer per channel, states IDLE, START, DATA, STOP.
  - IDLE -> START: when hold_full && enable. The hold moves to the shift register, hold_full clears, and mode is latched for the whole frame.
  - For a write accepted at E with the channel idle, the start bit is on tx_out from edge E+2.
  - Frame: start bit 0, then DATA_WIDTH data bits LSB first, then stop bit 1. Each bit lasts BIT_CYCLES cycles, a modulo counter.
  - STOP end: go to START if hold_full && enable (no idle gap), else IDLE.
  - tx_busy=1 in START, DATA and STOP.
- Encoding:
  - NRZ: tx_out equals the bit value.
  - Manchester: first half = ~bit, second half = bit, applied to start, data and stop bits. Idle stays constant 1.
- enable cleared mid-frame: the current frame completes and no new load occurs; hold data is retained.
- Mode written mid-frame: takes effect only at the next frame load.
- Channels are fully independent; simultaneous frame starts are allowed.

Decomposition:
- Package bsg_mc_pkg holds:
  - mode_t enum (MODE_NRZ, MODE_MANCH).
  - ser_state_t enum (IDLE, START, DATA, STOP).
  - Constants ADDR_CTRL=0x20, ADDR_STATUS=0x21, CTRL_RST=0x01.
- One sub-module, bsg_ch_serializer: hold register, state machine, bit counter and encoder. It is instantiated NUM_CH times in a generate loop.
- The top level holds the register decode, the ready logic and the read mux.

Test Plan:
- All tests use DATA_WIDTH=8, NUM_CH=4, BIT_CYCLES=4.
- Reset, then read 0xA0 and 0xA1 -> tx_out=4'hF, ready=1; CTRL reads 0x01 and STATUS reads 0x00 one cycle after acceptance.
- Write 0xA5 to addr 0x00 (NRZ) -> tx_out[0] from E+2 gives 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_busy[0] is high exactly 40 cycles, then the line is 1.
- Write 0x01 then 0x02 to addr 0x01 -> ready=0 while the hold is full. The two frames are contiguous (80 busy cycles), with no idle cycle between the stop and the next start.
- Write CTRL=0x03, then 0x00 to addr 0x02 -> start and data bits are 1,1,0,0 each; the stop bit is 0,0,1,1. A mode write of 0x01 mid-frame does not alter the current frame.
- Mid-frame CTRL=0x00 on ch3 with its hold full -> the frame completes, tx_busy[3] falls, and the hold stays full (STATUS bit3=1). Re-enabling starts the frame. rst mid-frame -> tx_out=1 next cycle and STATUS=0.
- Writes 0x11, 0x22, 0x33, 0x44 to channels 0..3 on consecutive cycles -> four independent correct frames, each starting 1 cycle apart. STATUS reads 0xF0 while all are busy.
